// File: rtl/wddl_pkg.sv
// Shared definitions for the WDDL dual-rail register stage.
//   state_e    : stage FSM encoding (PRE, WAIT, EVAL, DONE)
//   PRECHARGE  : rail value driven during the precharge wave
//   cnt_width  : width of the phase counter for given EVAL/PRE cycle counts
package wddl_pkg;

    typedef enum logic [1:0] {
        StPre  = 2'd0,
        StWait = 2'd1,
        StEval = 2'd2,
        StDone = 2'd3
    } state_e;

    // Both rails low is the precharge (spacer) codeword.
    localparam logic PRECHARGE = 1'b0;

    // One extra bit over the largest terminal count so the counter can never wrap.
    function automatic int unsigned cnt_width(input int unsigned eval_cycles,
                                              input int unsigned pre_cycles);
        int unsigned max_cycles;
        max_cycles = (eval_cycles > pre_cycles) ? eval_cycles : pre_cycles;
        return unsigned'($clog2(max_cycles)) + 1;
    endfunction

endpackage

// File: rtl/wddl_rail_check.sv
// Combinational dual-rail codeword checker.
//   d_p_i, d_n_i : true / false rails of the incoming word
//   err_o        : per-bit flag, set where the rails are not complementary
//   any_err_o    : OR of err_o
module wddl_rail_check #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] d_p_i,
    input  logic [WIDTH-1:0] d_n_i,
    output logic [WIDTH-1:0] err_o,
    output logic             any_err_o
);

    always_comb begin
        err_o     = ~(d_p_i ^ d_n_i);
        any_err_o = |err_o;
    end

endmodule

// File: rtl/wddl_dr_stage.sv
// Dual-rail register stage feeding WDDL XOR operand trees.
// Captures one word per handshake, drives it for an evaluation window, holds it until
// downstream accepts, then precharges all rails to 0/0 before the next capture.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : upstream handshake; d_p_in / d_n_in sampled on capture
//   out_valid / out_ready: downstream handshake; d_p_out / d_n_out drive the XOR tree
//   err_clr              : clears code_err and err_mask
//   code_err             : sticky flag, some captured bit had p == n
//   err_mask             : offending bits of the most recent faulty capture
module wddl_dr_stage
    import wddl_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned EVAL_CYCLES = 2,
    parameter int unsigned PRE_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_p_in,
    input  logic [WIDTH-1:0] d_n_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_p_out,
    output logic [WIDTH-1:0] d_n_out,
    input  logic             err_clr,
    output logic             code_err,
    output logic [WIDTH-1:0] err_mask
);

    localparam int unsigned      CntW      = cnt_width(EVAL_CYCLES, PRE_CYCLES);
    localparam logic [CntW-1:0]  PreLast   = CntW'(PRE_CYCLES - 1);
    localparam logic [CntW-1:0]  EvalLast  = CntW'(EVAL_CYCLES - 1);
    localparam logic [WIDTH-1:0] RailsIdle = {WIDTH{PRECHARGE}};

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  p_q, p_d;
    logic [WIDTH-1:0]  n_q, n_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              code_err_q, code_err_d;
    logic [WIDTH-1:0]  err_mask_q, err_mask_d;

    logic [WIDTH-1:0]  chk_err;
    logic              chk_any;
    logic              capture;

    wddl_rail_check #(
        .WIDTH (WIDTH)
    ) u_rail_check (
        .d_p_i     (d_p_in),
        .d_n_i     (d_n_in),
        .err_o     (chk_err),
        .any_err_o (chk_any)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        n_d        = n_q;
        capture    = 1'b0;
        code_err_d = code_err_q;
        err_mask_d = err_mask_q;

        unique case (state_q)
            StPre: begin
                if (cnt_q == PreLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                // in_ready is exactly "state is WAIT", so in_valid alone completes the handshake.
                if (in_valid) begin
                    state_d = StEval;
                    cnt_d   = '0;
                    p_d     = d_p_in;
                    n_d     = d_n_in;
                    capture = 1'b1;
                end
            end
            StEval: begin
                if (cnt_q == EvalLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StPre;
                    cnt_d   = '0;
                    p_d     = RailsIdle;
                    n_d     = RailsIdle;
                end
            end
            default: begin
                state_d = StPre;
                cnt_d   = '0;
                p_d     = RailsIdle;
                n_d     = RailsIdle;
            end
        endcase

        // A faulty capture overrides a same-cycle clear.
        if (err_clr) begin
            code_err_d = 1'b0;
            err_mask_d = '0;
        end
        if (capture && chk_any) begin
            code_err_d = 1'b1;
            err_mask_d = chk_err;
        end

        in_ready_d  = (state_d == StWait);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPre;
            cnt_q       <= '0;
            p_q         <= RailsIdle;
            n_q         <= RailsIdle;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            err_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            n_q         <= n_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            code_err_q  <= code_err_d;
            err_mask_q  <= err_mask_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d_p_out   = p_q;
    assign d_n_out   = n_q;
    assign code_err  = code_err_q;
    assign err_mask  = err_mask_q;

endmodule
